kgp_instr_encoder: RTL
======================

Name: kgp_instr_encoder

Overview:
- Program-load encoder for the KGP-RISC core; performs the reverse of the instruction decode.
- Accepts one symbolic instruction per handshake (mnemonic code plus operand fields) and packs it into the 32-bit KGP-RISC instruction format.
- Writes each packed word sequentially into instruction memory through a registered write port with backpressure.
- Sits between the test/boot loader and the instruction memory; the core is held idle while this block runs.

Parameters:
- AW, 8, instruction-memory word-address width
- DEPTH, 256, words available; must satisfy DEPTH <= 2**AW

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse: clear address, count and error; enter LOAD
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept this cycle
- in_last  in  1  current instruction is the final one of the program
- in_mnem  in  5  mnemonic code (see package)
- in_rs  in  5  source register 1
- in_rt  in  5  source register 2, or destination for I/LD/ST
- in_rd  in  5  destination register (R-type)
- in_imm  in  26  immediate/offset; low bits used per format
- imem_we  out  1  write strobe, held until imem_ready
- imem_addr  out  AW  word address
- imem_wdata  out  32  encoded instruction
- imem_ready  in  1  memory accepts the write this cycle
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when the last word is written
- err  out  1  sticky: illegal mnemonic seen or overflow
- count  out  AW+1  words written since start

Behaviour:
- Reset: all outputs 0, state IDLE, address 0.
- Encoding: opcode occupies [31:26].
  - R-type: opcode 000000, rs [25:21], rt [20:16], rd [15:11], [10:6]=0, funct [5:0] = 1..10 for ADD,SUB,AND,OR,XOR,NOT,SLA,SLL,SRA,SRL.
  - I-type: opcode 010000..011010 for ADDI,SUBI,ANDI,ORI,XORI,NOTI,SLAI,SLLI,SRAI,SRLI,MOVE; rs [25:21], rt [20:16], imm[15:0] in [15:0].
  - LD: opcode 100001. ST: opcode 100010. Both use the I-type layout.
  - BR: opcode 110000, in_imm[25:0] in [25:0].
  - BMI/BPL/BZ: opcodes 110001/110010/110011, rs [25:21], in_imm[20:0] in [20:0].
  - Unused fields are forced to 0.
- FSM states:
  - IDLE: in_ready=0; start moves to LOAD.
  - LOAD: accepting instructions.
  - DRAIN: last word captured; waiting for its write to complete.
  - IDLE again on completion.
- Handshake:
  - Transfer occurs when in_valid && in_ready.
  - in_ready = (state==LOAD) && (!imem_we || imem_ready) && (count + pending < DEPTH).
- Latency: a word accepted at cycle N drives imem_we/addr/wdata at N+1 from a one-entry output register.
  - Holds stable while imem_ready=0.
  - Back-to-back writes are allowed at full throughput when imem_ready=1.
- Address and count:
  - imem_addr and count increment when imem_we && imem_ready.
  - imem_addr starts at 0 and never wraps.
  - When count reaches DEPTH with the program not finished: err=1, state goes to IDLE, no done pulse.
- Illegal mnemonic (code >= 27) on transfer:
  - Word dropped, err set, no address advance.
  - If in_last was set, go directly to IDLE and pulse done the next cycle.
- in_last accepted: state goes to DRAIN. When that write completes, pulse done for 1 cycle and go to IDLE.
- Simultaneous events:
  - start in LOAD/DRAIN aborts: any pending write is discarded, imem_we is dropped next cycle, counters and err clear, state returns to LOAD.
  - start has priority over a same-cycle transfer, which is ignored.
- Reset mid-operation: immediately clears everything, including the held imem_we.

Decomposition:
- Shared package kgp_isa_pkg:
  - mnemonic enum (5-bit, ADD=0 … BZ=26)
  - opcode/funct constants
  - field bit-position localparams, reused by the core controller
- Sub-module kgp_instr_pack: purely combinational mnemonic+fields to {legal, word[31:0]}.
- Top module holds the FSM, output register and counters.

Test Plan:
- start; ADD rs=1 rt=2 rd=3 with in_last, imem_ready=1 -> cycle+1: imem_we=1, addr=0, wdata=0x00221801; done pulses the following cycle, count=1.
- ADDI rs=4 rt=5 imm=0xFFFF, then LD rs=6 rt=7 imm=0x0010, back-to-back -> wdata 0x4085FFFF at addr 0, then 0x84C70010 at addr 1, with no bubble.
- BR imm=0x3FFFFFF; BZ rs=9 imm=0x1FFFFF -> 0xC3FFFFFF, then 0xCD3FFFFF.
- imem_ready held 0 for 3 cycles during a write -> imem_we, addr and wdata stable; in_ready=0; write completes on the 4th cycle.
- mnem=30 mid-stream -> err=1, no write, next legal word lands at the unchanged address; DEPTH=4 with 5 instructions -> err=1, no done, busy=0.
- start asserted while a write is stalled -> imem_we=0 next cycle, count=0, err=0; asynchronous reset mid-LOAD -> all outputs 0 immediately.

Source files
------------

// File: rtl/kgp_isa_pkg.sv
// KGP-RISC ISA definitions shared by the program-load encoder and the core controller:
// mnemonic codes, opcode/funct constants and instruction field positions.
package kgp_isa_pkg;

   typedef enum logic [4:0] {
      MN_ADD,  MN_SUB,  MN_AND,  MN_OR,   MN_XOR,
      MN_NOT,  MN_SLA,  MN_SLL,  MN_SRA,  MN_SRL,
      MN_ADDI, MN_SUBI, MN_ANDI, MN_ORI,  MN_XORI,
      MN_NOTI, MN_SLAI, MN_SLLI, MN_SRAI, MN_SRLI,
      MN_MOVE, MN_LD,   MN_ST,   MN_BR,   MN_BMI,
      MN_BPL,  MN_BZ
   } mnem_e;

   localparam int OPC_W     = 6;
   localparam int REG_W     = 5;
   localparam int FUNCT_W   = 6;
   localparam int OPC_LSB   = 26;
   localparam int RS_LSB    = 21;
   localparam int RT_LSB    = 16;
   localparam int RD_LSB    = 11;
   localparam int FUNCT_LSB = 0;
   localparam int IMM16_W   = 16;
   localparam int IMM21_W   = 21;
   localparam int IMM26_W   = 26;

   localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b000000;
   localparam logic [OPC_W-1:0] OPC_IBASE = 6'b010000;
   localparam logic [OPC_W-1:0] OPC_LD    = 6'b100001;
   localparam logic [OPC_W-1:0] OPC_ST    = 6'b100010;
   localparam logic [OPC_W-1:0] OPC_BR    = 6'b110000;
   localparam logic [OPC_W-1:0] OPC_BCOND = 6'b110001;

endpackage

// File: rtl/kgp_instr_pack.sv
// Combinational packer: one symbolic KGP-RISC instruction into its 32-bit machine word.
// Codes past BZ are reported as illegal with an all-zero word.
module kgp_instr_pack
   import kgp_isa_pkg::*;
(
   input  logic [4:0]  mnem,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [25:0] imm,
   output logic        legal,
   output logic [31:0] word
);

   always_comb begin
      legal = 1'b1;
      word  = '0;
      if (mnem <= MN_SRL) begin
         word[OPC_LSB +: OPC_W]     = OPC_RTYPE;
         word[RS_LSB +: REG_W]      = rs;
         word[RT_LSB +: REG_W]      = rt;
         word[RD_LSB +: REG_W]      = rd;
         word[FUNCT_LSB +: FUNCT_W] = FUNCT_W'(mnem) + FUNCT_W'(1);
      end else if (mnem <= MN_ST) begin
         // I-type ALU ops and MOVE occupy one contiguous opcode run; LD/ST sit apart
         if (mnem <= MN_MOVE)
            word[OPC_LSB +: OPC_W] = OPC_IBASE + OPC_W'(mnem - MN_ADDI);
         else if (mnem == MN_LD)
            word[OPC_LSB +: OPC_W] = OPC_LD;
         else
            word[OPC_LSB +: OPC_W] = OPC_ST;
         word[RS_LSB +: REG_W]   = rs;
         word[RT_LSB +: REG_W]   = rt;
         word[IMM16_W-1:0]       = imm[IMM16_W-1:0];
      end else if (mnem == MN_BR) begin
         word[OPC_LSB +: OPC_W]  = OPC_BR;
         word[IMM26_W-1:0]       = imm;
      end else if (mnem <= MN_BZ) begin
         word[OPC_LSB +: OPC_W]  = OPC_BCOND + OPC_W'(mnem - MN_BMI);
         word[RS_LSB +: REG_W]   = rs;
         word[IMM21_W-1:0]       = imm[IMM21_W-1:0];
      end else begin
         legal = 1'b0;
      end
   end

endmodule

// File: rtl/kgp_instr_encoder.sv
// Program-load encoder: accepts symbolic instructions, packs them and streams the words
// into instruction memory through a one-entry registered write port with backpressure.
module kgp_instr_encoder
   import kgp_isa_pkg::*;
#(
   parameter int AW    = 8,
   parameter int DEPTH = 256
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_last,
   input  logic [4:0]    in_mnem,
   input  logic [4:0]    in_rs,
   input  logic [4:0]    in_rt,
   input  logic [4:0]    in_rd,
   input  logic [25:0]   in_imm,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   input  logic          imem_ready,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW:0]   count
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_e;

   localparam logic [AW+1:0] DEPTH_EXT = (AW+2)'(DEPTH);

   state_e        state;
   logic          legal;
   logic [31:0]   word;
   logic          accept;
   logic          write_done;
   logic [AW+1:0] occupancy;
   logic [AW+1:0] count_inc;

   kgp_instr_pack u_pack (
      .mnem  (in_mnem),
      .rs    (in_rs),
      .rt    (in_rt),
      .rd    (in_rd),
      .imm   (in_imm),
      .legal (legal),
      .word  (word)
   );

   // Occupancy counts the word still waiting in the output register, so the
   // memory can never be asked to take more than DEPTH words.
   assign write_done = imem_we && imem_ready;
   assign occupancy  = {1'b0, count} + (AW+2)'(imem_we);
   assign count_inc  = {1'b0, count} + (AW+2)'(1);
   assign in_ready   = (state == S_LOAD) && (!imem_we || imem_ready) && (occupancy < DEPTH_EXT);
   assign accept     = in_valid && in_ready;
   assign busy       = (state != S_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         count      <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            state     <= S_LOAD;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            err       <= 1'b0;
            count     <= '0;
         end else begin
            if (write_done) begin
               imem_we <= 1'b0;
               count   <= count + (AW+1)'(1);
               if (imem_addr != {AW{1'b1}})
                  imem_addr <= imem_addr + AW'(1);
            end
            case (state)
               S_LOAD: begin
                  if (accept) begin
                     if (legal) begin
                        imem_we    <= 1'b1;
                        imem_wdata <= word;
                        if (in_last)
                           state <= S_DRAIN;
                     end else begin
                        err <= 1'b1;
                        if (in_last) begin
                           state <= S_IDLE;
                           done  <= 1'b1;
                        end
                     end
                  end else if (write_done && count_inc == DEPTH_EXT) begin
                     // memory full before the program's last instruction arrived
                     err   <= 1'b1;
                     state <= S_IDLE;
                  end
               end
               S_DRAIN: begin
                  if (write_done) begin
                     done  <= 1'b1;
                     state <= S_IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
